async_fifo_reader: RTL and testbench

Read-side drain engine for the async FIFO, running entirely in the read clock domain. Pops words through the FIFO's `rd`/`empty`/`dataout` port, absorbs the FIFO RAM's one-cycle read latency, and presents a valid/ready stream with `m_last` framing to downstream logic. Sustains one word per clock while the FIFO is non-empty and downstream holds `m_ready` high.

---
 rtl/async_fifo_reader_if.sv | 24 ++
 rtl/async_fifo_reader.sv | 144 ++++++++++++++
 tb/tb_async_fifo_reader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_reader_if.sv
// Output stream bundle of the async FIFO read-side drain engine:
// valid/ready handshake with data and frame-last marker.
interface async_fifo_reader_if #(
    parameter int WIDTH = 8
) ();
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/async_fifo_reader.sv
// Read-domain drain engine: pops the async FIFO, absorbs its one-cycle RAM latency
// and streams words with frame framing. Optional word counter: ASYNC_FIFO_RD_WORDCNT_EN.
module async_fifo_reader #(
    parameter int WIDTH    = 8,
    parameter int FRAMELEN = 4
) (
    input  logic                rdclk,
    input  logic                reset,
    input  logic                fifo_empty,
    input  logic [WIDTH-1:0]    fifo_dataout,
    output logic                fifo_rd,
    input  logic                en,
    async_fifo_reader_if.master m
`ifdef ASYNC_FIFO_RD_WORDCNT_EN
    ,
    output logic [31:0]         word_count
`endif
);

    localparam logic [15:0] LAST_BEAT = 16'(FRAMELEN - 1);

    logic [1:0]       cnt_q, cnt_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [15:0]      frame_q, frame_d;

    logic [1:0]       occ_s;
    logic [1:0]       after_s;
    logic             m_valid_s;
    logic             accept_s;

    // The in-flight word counts as occupancy: it is shown straight from the FIFO
    // output register while it is the oldest word, so no latency is added.
    assign occ_s     = cnt_q + {1'b0, inflight_q};
    assign m_valid_s = (occ_s != 2'd0);
    assign accept_s  = m_valid_s && m.m_ready;
    assign after_s   = occ_s - {1'b0, accept_s};

    assign fifo_rd   = reset && en && !fifo_empty && (after_s < 2'd2);
    assign m.m_valid = m_valid_s;
    assign m.m_data  = ((cnt_q == 2'd0) && inflight_q) ? fifo_dataout : head_q;
    assign m.m_last  = m_valid_s && (frame_q == LAST_BEAT);

    // Buffer next-state: drop the accepted head, then append the captured word.
    always_comb begin
        cnt_d      = cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = fifo_rd;
        case ({inflight_q, accept_s})
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end else begin
                    cnt_d  = 2'd0;
                end
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = fifo_dataout;
                    cnt_d  = 2'd1;
                end else begin
                    tail_d = fifo_dataout;
                    cnt_d  = 2'd2;
                end
            end
            2'b11: begin
                // With nothing stored the in-flight word itself was just accepted.
                if (cnt_q == 2'd0) begin
                    cnt_d  = 2'd0;
                end else if (cnt_q == 2'd1) begin
                    head_d = fifo_dataout;
                    cnt_d  = 2'd1;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_dataout;
                    cnt_d  = 2'd2;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Frame position of the next beat to be accepted.
    always_comb begin
        frame_d = frame_q;
        if (accept_s) begin
            if (frame_q == LAST_BEAT) begin
                frame_d = 16'd0;
            end else begin
                frame_d = frame_q + 16'd1;
            end
        end else begin
            frame_d = frame_q;
        end
    end

    // Buffer, in-flight flag and frame position registers.
    always_ff @(posedge rdclk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            frame_q    <= 16'd0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            frame_q    <= frame_d;
        end
    end

`ifdef ASYNC_FIFO_RD_WORDCNT_EN
    logic [31:0] wcnt_q, wcnt_d;

    // Delivered-beat count, wraps naturally at 32 bits.
    always_comb begin
        wcnt_d = wcnt_q;
        if (accept_s) begin
            wcnt_d = wcnt_q + 32'd1;
        end else begin
            wcnt_d = wcnt_q;
        end
    end

    // Delivered-beat counter register.
    always_ff @(posedge rdclk or negedge reset) begin
        if (!reset) begin
            wcnt_q <= 32'd0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign word_count = wcnt_q;
`endif

endmodule

// File: tb/tb_async_fifo_reader.sv
// Directed bench for async_fifo_reader with a behavioural registered-output FIFO.
module tb_async_fifo_reader;
    logic       rdclk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dataout = 8'h00;
    logic       fifo_rd;
`ifdef ASYNC_FIFO_RD_WORDCNT_EN
    logic [31:0] word_count;
`endif

    async_fifo_reader_if #(.WIDTH(8)) s_if ();

    async_fifo_reader #(.WIDTH(8), .FRAMELEN(4)) dut (
        .rdclk        (rdclk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_dataout (fifo_dataout),
        .fifo_rd      (fifo_rd),
        .en           (en),
        .m            (s_if)
`ifdef ASYNC_FIFO_RD_WORDCNT_EN
        ,
        .word_count   (word_count)
`endif
    );

    always #5 rdclk = ~rdclk;

    int checks = 0;
    int failures = 0;

    // FIFO model: registered empty and registered read data.
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;

    always @(posedge rdclk) begin
        if (fifo_rd && !fifo_empty) begin
            fifo_dataout <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
            fifo_empty   <= (wr_ptr == rd_ptr + 1);
        end else begin
            fifo_empty   <= (wr_ptr == rd_ptr);
        end
    end

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // Monitor: records delivered beats, pops and pops-while-empty.
    logic [7:0] bq[$];
    logic       lq[$];
    int         cq[$];
    int cyc = 0;
    int pops = 0;
    int viol = 0;

    always @(negedge rdclk) begin
        cyc = cyc + 1;
        if (reset) begin
            if (fifo_rd) pops = pops + 1;
            if (fifo_rd && fifo_empty) viol = viol + 1;
            if (s_if.m_valid && s_if.m_ready) begin
                bq.push_back(s_if.m_data);
                lq.push_back(s_if.m_last);
                cq.push_back(cyc);
            end
        end
    end

    task automatic clear_mon();
        bq.delete();
        lq.delete();
        cq.delete();
        pops = 0;
        viol = 0;
    endtask

    task automatic wait_beats(input int n, input int limit);
        int k = 0;
        while (bq.size() < n && k < limit) begin
            @(negedge rdclk);
            k++;
        end
    endtask

    task automatic apply_reset();
        @(posedge rdclk); #1;
        reset = 1'b0;
        @(posedge rdclk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b1;
        s_if.m_ready = 1'b1;
        #2;
        checks++; if (s_if.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", s_if.m_valid); end
        checks++; if (s_if.m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b exp=0", s_if.m_last); end
        checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_fifo_rd got=%b exp=0", fifo_rd); end
        checks++; if (s_if.m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data got=%h exp=00", s_if.m_data); end
`ifdef ASYNC_FIFO_RD_WORDCNT_EN
        checks++; if (word_count !== 32'd0) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
`endif
        @(posedge rdclk); #1;
        reset = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        clear_mon();
        push(8'hA5);
        @(negedge rdclk);
        checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL single_rd_before got=%b exp=0", fifo_rd); end
        @(negedge rdclk);
        checks++; if (fifo_rd !== 1'b1) begin failures++; $display("FAIL single_rd_pulse got=%b exp=1", fifo_rd); end
        @(negedge rdclk);
        checks++; if (s_if.m_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", s_if.m_valid); end
        checks++; if (s_if.m_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", s_if.m_data); end
        checks++; if (s_if.m_last !== 1'b0) begin failures++; $display("FAIL single_last got=%b exp=0", s_if.m_last); end
        checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL single_rd_after got=%b exp=0", fifo_rd); end
        @(negedge rdclk);
        checks++; if (s_if.m_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop got=%b exp=0", s_if.m_valid); end
        checks++; if (pops !== 1) begin failures++; $display("FAIL single_pops got=%0d exp=1", pops); end
    endtask

    task automatic test_stream();
        apply_reset();
        clear_mon();
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_beats(8, 40);
        @(posedge rdclk); #1;
        checks++; if (bq.size() !== 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", bq.size()); end
        for (int i = 0; i < 8 && i < bq.size(); i++) begin
            checks++; if (bq[i] !== 8'(i + 1)) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, bq[i], 8'(i + 1)); end
            checks++; if (lq[i] !== ((i % 4) == 3)) begin failures++; $display("FAIL stream_last[%0d] got=%b exp=%b", i, lq[i], ((i % 4) == 3)); end
        end
        if (bq.size() == 8) begin
            checks++; if (cq[7] - cq[0] !== 7) begin failures++; $display("FAIL stream_gapless got=%0d exp=7", cq[7] - cq[0]); end
        end
`ifdef ASYNC_FIFO_RD_WORDCNT_EN
        checks++; if (word_count !== 32'd8) begin failures++; $display("FAIL stream_word_count got=%0d exp=8", word_count); end
`endif
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        s_if.m_ready = 1'b0;
        apply_reset();
        clear_mon();
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        repeat (10) begin
            @(negedge rdclk);
            if (s_if.m_valid && (s_if.m_data !== 8'h10 || s_if.m_last !== 1'b0)) unstable++;
        end
        checks++; if (pops !== 2) begin failures++; $display("FAIL bp_pops got=%0d exp=2", pops); end
        checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL bp_rd got=%b exp=0", fifo_rd); end
        checks++; if (s_if.m_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", s_if.m_valid); end
        checks++; if (s_if.m_data !== 8'h10) begin failures++; $display("FAIL bp_data got=%h exp=10", s_if.m_data); end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
        @(posedge rdclk); #1;
        s_if.m_ready = 1'b1;
        wait_beats(4, 30);
        repeat (3) @(negedge rdclk);
        checks++; if (bq.size() !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", bq.size()); end
        for (int i = 0; i < 4 && i < bq.size(); i++) begin
            checks++; if (bq[i] !== 8'h10 + 8'(i)) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, bq[i], 8'h10 + 8'(i)); end
        end
        checks++; if (pops !== 4) begin failures++; $display("FAIL bp_total_pops got=%0d exp=4", pops); end
    endtask

    task automatic test_empty_boundary();
        apply_reset();
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            push(8'h20 + 8'(i));
            repeat (3) @(posedge rdclk);
            #1;
        end
        repeat (6) @(posedge rdclk);
        #1;
        checks++; if (viol !== 0) begin failures++; $display("FAIL eb_rd_while_empty got=%0d exp=0", viol); end
        checks++; if (bq.size() !== 6) begin failures++; $display("FAIL eb_count got=%0d exp=6", bq.size()); end
        for (int i = 0; i < 6 && i < bq.size(); i++) begin
            checks++; if (bq[i] !== 8'h20 + 8'(i)) begin failures++; $display("FAIL eb_data[%0d] got=%h exp=%h", i, bq[i], 8'h20 + 8'(i)); end
        end
        checks++; if (pops !== 6) begin failures++; $display("FAIL eb_pops got=%0d exp=6", pops); end
    endtask

    task automatic test_enable();
        apply_reset();
        en = 1'b0;
        clear_mon();
        push(8'h30); push(8'h31); push(8'h32);
        @(posedge rdclk); #1;
        en = 1'b1;
        @(negedge rdclk);
        checks++; if (fifo_rd !== 1'b1) begin failures++; $display("FAIL en_first_pop got=%b exp=1", fifo_rd); end
        @(posedge rdclk); #1;
        en = 1'b0;
        @(negedge rdclk);
        checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL en_gated got=%b exp=0", fifo_rd); end
        checks++; if (s_if.m_valid !== 1'b1) begin failures++; $display("FAIL en_inflight_valid got=%b exp=1", s_if.m_valid); end
        checks++; if (s_if.m_data !== 8'h30) begin failures++; $display("FAIL en_inflight_data got=%h exp=30", s_if.m_data); end
        repeat (5) @(negedge rdclk);
        checks++; if (bq.size() !== 1) begin failures++; $display("FAIL en_held_count got=%0d exp=1", bq.size()); end
        checks++; if (pops !== 1) begin failures++; $display("FAIL en_held_pops got=%0d exp=1", pops); end
        @(posedge rdclk); #1;
        en = 1'b1;
        wait_beats(3, 20);
        repeat (2) @(negedge rdclk);
        checks++; if (bq.size() !== 3) begin failures++; $display("FAIL en_count got=%0d exp=3", bq.size()); end
        for (int i = 0; i < 3 && i < bq.size(); i++) begin
            checks++; if (bq[i] !== 8'h30 + 8'(i)) begin failures++; $display("FAIL en_data[%0d] got=%h exp=%h", i, bq[i], 8'h30 + 8'(i)); end
        end
    endtask

    task automatic test_reset_midstream();
        int k = 0;
        apply_reset();
        en = 1'b1;
        s_if.m_ready = 1'b1;
        clear_mon();
        push(8'h3F);
        wait_beats(1, 20);
        @(posedge rdclk); #1;
`ifdef ASYNC_FIFO_RD_WORDCNT_EN
        checks++; if (word_count !== 32'd1) begin failures++; $display("FAIL rm_word_count_pre got=%0d exp=1", word_count); end
`endif
        s_if.m_ready = 1'b0;
        clear_mon();
        for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
        while (pops < 2 && k < 20) begin
            @(negedge rdclk);
            k++;
        end
        checks++; if (pops !== 2) begin failures++; $display("FAIL rm_pops got=%0d exp=2", pops); end
        @(posedge rdclk); #1;
        reset = 1'b0;
        #1;
        checks++; if (s_if.m_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", s_if.m_valid); end
        checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL rm_rd got=%b exp=0", fifo_rd); end
        checks++; if (s_if.m_last !== 1'b0) begin failures++; $display("FAIL rm_last got=%b exp=0", s_if.m_last); end
`ifdef ASYNC_FIFO_RD_WORDCNT_EN
        checks++; if (word_count !== 32'd0) begin failures++; $display("FAIL rm_word_count got=%0d exp=0", word_count); end
`endif
        @(posedge rdclk); #1;
        reset = 1'b1;
        s_if.m_ready = 1'b1;
        clear_mon();
        wait_beats(4, 20);
        repeat (3) @(negedge rdclk);
        checks++; if (bq.size() !== 4) begin failures++; $display("FAIL rm_count got=%0d exp=4", bq.size()); end
        for (int i = 0; i < 4 && i < bq.size(); i++) begin
            checks++; if (bq[i] !== 8'h42 + 8'(i)) begin failures++; $display("FAIL rm_data[%0d] got=%h exp=%h", i, bq[i], 8'h42 + 8'(i)); end
            checks++; if (lq[i] !== (i == 3)) begin failures++; $display("FAIL rm_last[%0d] got=%b exp=%b", i, lq[i], (i == 3)); end
        end
    endtask

    initial begin
        s_if.m_ready = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_empty_boundary();
        test_enable();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
